io_event_fifo: RTL and testbench

- Memory-mapped input-event FIFO that produces io_fifo_empty and io_fifo_dout for the memory read path (IO space 0x8000_0020 / 0x8000_0024).
- Captures one-cycle button pulses from the debouncer/edge detector as 8-bit event bytes.
- Presents the oldest byte first-word-fall-through, so the load path reads it combinationally in the same cycle.
- Pops exactly one entry per retired load from the data address.

---
 rtl/io_event_fifo_pkg.sv | 25 ++
 rtl/io_event_fifo_sync_fifo.sv | 58 +++++
 rtl/io_event_fifo.sv | 79 +++++++
 tb/tb_io_event_fifo.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/io_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
// io_event_fifo_pkg : opcode, funct3 and IO map constants shared with the core
// Revision: 1.0
// ============================================================================
package io_event_fifo_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [31:0] IO_FIFO_EMPTY_ADDR = 32'h8000_0020;
   localparam logic [31:0] IO_FIFO_DATA_ADDR  = 32'h8000_0024;

   function automatic logic is_load(input logic [31:0] instr);
      return instr[6:0] == OPC_LOAD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/io_event_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : first-word-fall-through synchronous FIFO, sync active-high reset
// Revision: 1.0
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   // A write into a full FIFO is only allowed when a read frees a slot this cycle.
   assign w_rd = rd_en && !empty;
   assign w_wr = wr_en && (!full || w_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= din;
   end

   assign dout  = r_mem[r_rd_ptr];
   assign empty = (r_count == '0);
   assign full  = (r_count == DEPTH[AW:0]);

endmodule
`default_nettype wire

// File: rtl/io_event_fifo.sv
`default_nettype none
// ============================================================================
// io_event_fifo : button-event FIFO on the IO load path, pops on data loads
// Revision: 1.0
// ============================================================================
module io_event_fifo
   import io_event_fifo_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter int          N_BUTTONS = 4,
   parameter logic [31:0] DATA_ADDR = IO_FIFO_DATA_ADDR
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_BUTTONS-1:0] button_pulses,
   input  logic [31:0]          instruction,
   input  logic [31:0]          mem_addr,
   input  logic                 stall,
   output logic                 io_fifo_empty,
   output logic [7:0]           io_fifo_dout,
   output logic                 io_fifo_full,
   output logic [7:0]           dropped_count
);

   logic       w_push_req;
   logic       w_pop_req;
   logic       w_push;
   logic       w_pop;
   logic       w_drop;
   logic       w_empty;
   logic       w_full;
   logic [7:0] w_din;
   logic [7:0] w_head;
   logic [7:0] r_dropped;
   logic       w_unused;

   // funct3 and the upper instruction bits do not qualify the pop.
   assign w_unused = ^instruction[31:7];

   always_comb begin
      w_din                = '0;
      w_din[N_BUTTONS-1:0] = button_pulses;
   end

   assign w_push_req = |button_pulses;
   assign w_pop_req  = is_load(instruction) && (mem_addr == DATA_ADDR) && !stall;
   assign w_pop      = w_pop_req && !w_empty;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_drop     = w_push_req && w_full && !w_pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (w_push),
      .din   (w_din),
      .rd_en (w_pop),
      .dout  (w_head),
      .empty (w_empty),
      .full  (w_full)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropped <= '0;
      end else if (w_drop && (r_dropped != 8'hFF)) begin
         r_dropped <= r_dropped + 8'd1;
      end
   end

   assign io_fifo_empty = w_empty;
   assign io_fifo_full  = w_full;
   assign io_fifo_dout  = w_empty ? 8'h00 : w_head;
   assign dropped_count = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_io_event_fifo.sv
`default_nettype none
// ============================================================================
// tb_io_event_fifo : directed vectors with hand-computed expectations
// Revision: 1.0
// ============================================================================
module tb_io_event_fifo;

   localparam logic [31:0] LBU  = 32'h0000_4003;
   localparam logic [31:0] LW   = 32'h0000_2003;
   localparam logic [31:0] SW   = 32'h0000_2023;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] DADR = 32'h8000_0024;
   localparam logic [31:0] EADR = 32'h8000_0020;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] button_pulses;
   logic [31:0] instruction;
   logic [31:0] mem_addr;
   logic       stall;
   logic       io_fifo_empty;
   logic [7:0] io_fifo_dout;
   logic       io_fifo_full;
   logic [7:0] dropped_count;

   int n_vec = 0;
   int n_err = 0;

   io_event_fifo #(
      .DEPTH     (8),
      .N_BUTTONS (4),
      .DATA_ADDR (32'h8000_0024)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .button_pulses (button_pulses),
      .instruction   (instruction),
      .mem_addr      (mem_addr),
      .stall         (stall),
      .io_fifo_empty (io_fifo_empty),
      .io_fifo_dout  (io_fifo_dout),
      .io_fifo_full  (io_fifo_full),
      .dropped_count (dropped_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: apply inputs across one posedge, return at next negedge idle.
   task automatic cyc(input logic [3:0] p, input logic [31:0] ins,
                      input logic [31:0] a, input logic st);
      button_pulses = p;
      instruction   = ins;
      mem_addr      = a;
      stall         = st;
      @(negedge clk);
      button_pulses = '0;
      instruction   = NOP;
      mem_addr      = '0;
      stall         = 1'b0;
   endtask

   task automatic push(input logic [3:0] p);
      cyc(p, NOP, 32'h0, 1'b0);
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] exp);
      chk(tag, {24'h0, io_fifo_dout}, {24'h0, exp});
      cyc(4'h0, LBU, DADR, 1'b0);
   endtask

   initial begin
      logic [3:0] seq4 [8];
      rst = 1'b1;
      button_pulses = '0;
      instruction = NOP;
      mem_addr = '0;
      stall = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 1: reset state
      chk("rst_empty", {31'h0, io_fifo_empty}, 32'd1);
      chk("rst_full",  {31'h0, io_fifo_full},  32'd0);
      chk("rst_dout",  {24'h0, io_fifo_dout},  32'h00);
      chk("rst_drop",  {24'h0, dropped_count}, 32'd0);

      // 2: in-order read, multi-bit pulse is one entry
      push(4'b0001);
      push(4'b0110);
      push(4'b1000);
      chk("t2_nonempty", {31'h0, io_fifo_empty}, 32'd0);
      pop_chk("t2_pop0", 8'h01);
      pop_chk("t2_pop1", 8'h06);
      pop_chk("t2_pop2", 8'h08);
      chk("t2_empty", {31'h0, io_fifo_empty}, 32'd1);
      chk("t2_dout0", {24'h0, io_fifo_dout},  32'h00);

      // 3: overflow of ten pushes into eight slots
      for (int i = 1; i <= 10; i++) begin
         push(4'(i));
         if (i == 7) chk("t3_notfull7", {31'h0, io_fifo_full}, 32'd0);
         if (i == 8) chk("t3_full8",    {31'h0, io_fifo_full}, 32'd1);
      end
      chk("t3_drop", {24'h0, dropped_count}, 32'd2);
      for (int i = 1; i <= 8; i++) begin
         chk("t3_pop", {24'h0, io_fifo_dout}, i);
         cyc(4'h0, LW, DADR, 1'b0);
      end
      chk("t3_ninth_dout",  {24'h0, io_fifo_dout},  32'h00);
      chk("t3_ninth_empty", {31'h0, io_fifo_empty}, 32'd1);
      cyc(4'h0, LW, DADR, 1'b0);
      chk("t3_after_empty_load", {31'h0, io_fifo_empty}, 32'd1);

      // 4: full, push and pop together
      seq4 = '{4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h1};
      for (int i = 0; i < 8; i++) push(seq4[i]);
      chk("t4_full", {31'h0, io_fifo_full}, 32'd1);
      chk("t4_head", {24'h0, io_fifo_dout}, 32'h09);
      cyc(4'b0011, LBU, DADR, 1'b0);
      chk("t4_still_full", {31'h0, io_fifo_full}, 32'd1);
      chk("t4_drop_same",  {24'h0, dropped_count}, 32'd2);
      for (int i = 1; i < 8; i++) pop_chk("t4_drain", {4'h0, seq4[i]});
      pop_chk("t4_last", 8'h03);
      chk("t4_empty", {31'h0, io_fifo_empty}, 32'd1);

      // 5: stalled load pops once; flag load and store never pop
      push(4'h5);
      push(4'h7);
      for (int i = 0; i < 3; i++) begin
         chk("t5_stall_dout", {24'h0, io_fifo_dout}, 32'h05);
         cyc(4'h0, LBU, DADR, 1'b1);
      end
      cyc(4'h0, LBU, DADR, 1'b0);
      chk("t5_one_pop", {24'h0, io_fifo_dout}, 32'h07);
      cyc(4'h0, LW, EADR, 1'b0);
      chk("t5_flag_load", {24'h0, io_fifo_dout}, 32'h07);
      cyc(4'h0, SW, DADR, 1'b0);
      chk("t5_store", {24'h0, io_fifo_dout}, 32'h07);
      pop_chk("t5_last", 8'h07);
      chk("t5_empty", {31'h0, io_fifo_empty}, 32'd1);

      // drop counter saturation on a full FIFO
      for (int i = 1; i <= 8; i++) push(4'(i));
      repeat (260) push(4'hF);
      chk("sat_drop", {24'h0, dropped_count}, 32'hFF);
      chk("sat_head", {24'h0, io_fifo_dout},  32'h01);
      for (int i = 1; i <= 5; i++) pop_chk("sat_drain", 8'(i));

      // 6: reset with pending push/pop discards three entries
      chk("t6_held", {24'h0, io_fifo_dout}, 32'h06);
      rst = 1'b1;
      cyc(4'h2, LBU, DADR, 1'b0);
      rst = 1'b0;
      chk("t6_empty", {31'h0, io_fifo_empty}, 32'd1);
      chk("t6_full",  {31'h0, io_fifo_full},  32'd0);
      chk("t6_drop",  {24'h0, dropped_count}, 32'd0);
      chk("t6_dout",  {24'h0, io_fifo_dout},  32'h00);
      push(4'b0100);
      chk("t6_nonempty", {31'h0, io_fifo_empty}, 32'd0);
      pop_chk("t6_readback", 8'h04);
      chk("t6_final_empty", {31'h0, io_fifo_empty}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
